crono_ctrl: RTL and testbench



---
 rtl/crono_pkg.sv | 9 +
 rtl/crono_ctrl_bcd_digit.sv | 21 ++
 rtl/crono_ctrl.sv | 100 ++++++++++
 tb/tb_crono_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/crono_pkg.sv
// crono_pkg: shared types and digit limits for the stopwatch sequencer
package crono_pkg;
    typedef logic [3:0]      bcd_t;
    typedef logic [7:0][3:0] time_t;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
    localparam bcd_t UNIT_MAX      = 4'd9;
    localparam bcd_t SIXTY_TENS    = 4'd5;
    localparam bcd_t HOUR_TENS_MAX = 4'd9;
endpackage

// File: rtl/crono_ctrl_bcd_digit.sv
// bcd_digit: one BCD digit of the time counter carry chain
module bcd_digit
    import crono_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output bcd_t q,
    output logic carry
);
    assign carry = inc && q == MAX;

    // advance on inc, wrapping to 0 after MAX; clr wins
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (clr) q <= '0;
        else if (inc) q <= carry ? '0 : q + 4'd1;
endmodule

// File: rtl/crono_ctrl.sv
// crono_ctrl: stopwatch sequencer (HH:MM:SS.cc); define CRONO_LAP_EN to build the lap-freeze feature
module crono_ctrl
    import crono_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start_stop,
    input  logic  lap_clear,
    output time_t value,
    output logic  running,
    output logic  lap_active,
    output logic  overflow
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    state_t        state, state_nx;
    logic [PW-1:0] pre;
    logic          counting, tick, clr;
    logic [8:0]    inc;
    time_t         cnt;

    assign counting = state == RUN || state == LAP;
    assign tick     = counting && pre == PW'(DIV - 1);
    assign clr      = state_nx == IDLE;
    assign inc[0]   = tick;

    // next state; start_stop wins over lap_clear in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_stop ? RUN : IDLE;
`ifdef CRONO_LAP_EN
            RUN:     state_nx = start_stop ? PAUSE : lap_clear ? LAP : RUN;
            LAP:     state_nx = start_stop ? PAUSE : LAP;
`else
            RUN:     state_nx = start_stop ? PAUSE : RUN;
`endif
            PAUSE:   state_nx = start_stop ? RUN : lap_clear ? IDLE : PAUSE;
            default: state_nx = IDLE;
        endcase
    end

    // state register with decodes of the next state and the sticky wrap flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            running  <= state_nx == RUN || state_nx == LAP;
            overflow <= clr ? 1'b0 : overflow | inc[8];
        end

    // prescaler: counts while running, holds in PAUSE, clears toward IDLE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pre <= '0;
        else if (clr) pre <= '0;
        else if (counting) pre <= tick ? '0 : pre + 1'b1;

    for (genvar i = 0; i < 8; i++) begin : g_dig
        bcd_digit #(
            .MAX(i == 3 || i == 5 ? SIXTY_TENS : i == 7 ? HOUR_TENS_MAX : UNIT_MAX)
        ) u_dig (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (inc[i]),
            .clr  (clr),
            .q    (cnt[i]),
            .carry(inc[i+1])
        );
    end

`ifdef CRONO_LAP_EN
    time_t lap;

    // lap capture takes the pre-increment count; display shows lap while in LAP
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lap        <= '0;
            lap_active <= 1'b0;
            value      <= '0;
        end else begin
            if (counting && lap_clear && !start_stop) lap <= cnt;
            lap_active <= state_nx == LAP;
            value      <= state == LAP ? lap : cnt;
        end
`else
    assign lap_active = 1'b0;

    // display always follows the live count
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) value <= '0;
        else value <= cnt;
`endif
endmodule

// File: tb/tb_crono_ctrl.sv
// tb_crono_ctrl: randomized and directed scoreboard bench for crono_ctrl
module tb_crono_ctrl;
    import crono_pkg::*;

    localparam int DIV  = 10;
    localparam int TMAX = 36_000_000;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
`ifdef CRONO_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    typedef struct packed {time_t v; logic r; logic l; logic o;} exp_t;

    logic  clk = 1'b0, rst_n = 1'b1, start_stop = 1'b0, lap_clear = 1'b0;
    time_t value;
    logic  running, lap_active, overflow;
    exp_t  sb[$];
    int    n_tot = 0, n_pass = 0;
    int    m_mode, m_t, m_lap, m_ph;
    bit    m_ovf;

    crono_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .lap_clear (lap_clear),
        .value     (value),
        .running   (running),
        .lap_active(lap_active),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic time_t disp(int t);
        int cs, s, m, h;
        cs = t % 100; s = t / 100 % 60; m = t / 6000 % 60; h = t / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic chk(input string nm, input logic [34:0] got, input logic [34:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, exp);
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_t = 0; m_lap = 0; m_ph = 0; m_ovf = 0;
    endtask

    // one clock of stimulus; the model predicts the outputs after the coming edge
    task automatic step(input bit ss, input bit lc);
        exp_t e;
        int   old;
        bit   tk;
        @(negedge clk);
        start_stop = ss; lap_clear = lc;
        old = m_mode;
        e.v = disp(old == M_LAP ? m_lap : m_t);
        tk  = (old == M_RUN || old == M_LAP) && m_ph == DIV - 1;
        case (old)
            M_IDLE:  if (ss) m_mode = M_RUN;
            M_RUN:   if (ss) m_mode = M_PAUSE;
                     else if (lc && LAP_EN) begin m_mode = M_LAP; m_lap = m_t; end
            M_LAP:   if (ss) m_mode = M_PAUSE; else if (lc) m_lap = m_t;
            default: if (ss) m_mode = M_RUN;
                     else if (lc) begin m_mode = M_IDLE; m_t = 0; m_ph = 0; m_ovf = 0; end
        endcase
        if (old == M_RUN || old == M_LAP) begin
            m_ph = tk ? 0 : m_ph + 1;
            if (tk) m_t = m_t + 1;
            if (m_t == TMAX) begin m_t = 0; m_ovf = 1; end
        end
        e.r = m_mode == M_RUN || m_mode == M_LAP;
        e.l = m_mode == M_LAP;
        e.o = m_ovf;
        sb.push_back(e);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 20000 && m_t != target; k++) step(0, 0);
        chk("run_to", 35'(m_t), 35'(target));
    endtask

    // monitor: compare every cycle's outputs with the oldest prediction
    initial forever begin
        exp_t e;
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cycle", {value, running, lap_active, overflow}, e);
        end
    end

    initial begin
        m_reset();
        #1 rst_n = 1'b0;
        #1 chk("reset", {value, running, lap_active, overflow}, '0);
        @(negedge clk); rst_n = 1'b1;
        // start at cycle 5, then fixed-time readings
        repeat (4) step(0, 0);
        step(1, 0);
        @(posedge clk); #2 chk("t1_running", 35'(running), 35'd1);
        repeat (101) step(0, 0);
        @(posedge clk); #2 chk("t1_0.10", 35'(value), 35'h10);
        repeat (900) step(0, 0);
        @(posedge clk); #2 chk("t1_1.00", 35'(value), 35'h100);
        // lap capture at 0.37, recapture at 0.50
        step(1, 0); step(0, 1); step(1, 0);
        run_to(37);
        step(0, 1);
        run_to(50);
        step(0, 1);
        repeat (20) step(0, 0);
        @(posedge clk); #2 chk("t2_value", 35'(value), LAP_EN ? 35'h50 : 35'h52);
        // simultaneous pulses: pause, no capture
        step(1, 1);
        @(posedge clk); #2 chk("t5_both", {running, lap_active}, 35'd0);
        // clear, pause at 0.12 for 55 clocks, resume
        step(0, 1); step(1, 0);
        run_to(12);
        step(1, 0);
        repeat (55) step(0, 0);
        step(1, 0);
        repeat (40) step(0, 0);
        // preload 99:59:59.99 while paused, resume through the wrap
        step(1, 0); step(0, 0);
        @(posedge clk); #2;
        force dut.g_dig[0].u_dig.q = 4'd9;
        force dut.g_dig[1].u_dig.q = 4'd9;
        force dut.g_dig[2].u_dig.q = 4'd9;
        force dut.g_dig[3].u_dig.q = 4'd5;
        force dut.g_dig[4].u_dig.q = 4'd9;
        force dut.g_dig[5].u_dig.q = 4'd5;
        force dut.g_dig[6].u_dig.q = 4'd9;
        force dut.g_dig[7].u_dig.q = 4'd9;
        m_t = TMAX - 1;
        step(0, 0);
        @(posedge clk); #2;
        release dut.g_dig[0].u_dig.q;
        release dut.g_dig[1].u_dig.q;
        release dut.g_dig[2].u_dig.q;
        release dut.g_dig[3].u_dig.q;
        release dut.g_dig[4].u_dig.q;
        release dut.g_dig[5].u_dig.q;
        release dut.g_dig[6].u_dig.q;
        release dut.g_dig[7].u_dig.q;
        chk("t4_preload", 35'(value), 35'h99595999);
        step(1, 0);
        for (int k = 0; k < 3 * DIV && !m_ovf; k++) step(0, 0);
        step(0, 0);
        @(posedge clk); #2 chk("t4_wrap", {value, overflow}, 35'd1);
        step(1, 0); step(0, 1); step(0, 0);
        @(posedge clk); #2 chk("t4_ovf_clr", 35'(overflow), 35'd0);
        // asynchronous reset mid-run, off the clock edge
        step(1, 0);
        repeat (37) step(0, 0);
        @(negedge clk); start_stop = 1'b0; lap_clear = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk("t5_async_rst", {value, running, lap_active, overflow}, '0);
        sb.delete();
        m_reset();
        @(negedge clk); rst_n = 1'b1;
        // randomized command stream
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4);
        @(negedge clk); start_stop = 1'b0; lap_clear = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("drain", 35'(sb.size()), 35'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
